// File: rtl/uart_transmitter.sv
// Buffered UART transmitter: valid/ready FIFO in front of an LSB-first
// serialiser with configurable data width, parity, stop bits and baud divisor.
module uart_transmitter #(
  parameter int unsigned CLK_DIV    = 10416,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  input  logic [DATA_BITS-1:0]          tx_data,
  output logic                          uart_tx,
  output logic                          tx_busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned TMR_W = $clog2(CLK_DIV);
  localparam int unsigned BIT_W = $clog2(DATA_BITS);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  // FIFO storage and bookkeeping
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 ready_q;
  logic                 push, pop;

  // Serialiser state
  state_e               state_q, state_d;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [DATA_BITS-1:0] head;
  logic                 last_tick;
  logic                 load;

  assign push      = tx_valid & ready_q;
  assign head      = mem_q[rd_ptr_q];
  assign last_tick = (timer_q == TMR_W'(CLK_DIV - 1));

  // FIFO data array; written only on an accepted handshake
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= tx_data;
    end
  end

  // Next FIFO occupancy; push and pop together cancel out
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO pointers, count and ready flag
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_d;
      ready_q <= (count_d < CNT_W'(FIFO_DEPTH));
    end
  end

  // Frame sequencing, bit timing and registered line/status decode
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    pop     = 1'b0;
    load    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          load = 1'b1;
        end
      end

      S_START: begin
        if (last_tick) begin
          timer_d = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      S_DATA: begin
        if (last_tick) begin
          timer_d = '0;
          shift_d = shift_q >> 1;
          if (bit_q == BIT_W'(DATA_BITS - 1)) begin
            bit_d   = '0;
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      S_PARITY: begin
        if (last_tick) begin
          timer_d = '0;
          bit_d   = '0;
          state_d = S_STOP;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      S_STOP: begin
        if (last_tick) begin
          timer_d = '0;
          if (bit_q == BIT_W'(STOP_BITS - 1)) begin
            bit_d = '0;
            if (count_q != '0) begin
              load = 1'b1;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        timer_d = '0;
        bit_d   = '0;
      end
    endcase

    // Pop the head character and begin a new frame with a fresh bit timer
    if (load) begin
      pop     = 1'b1;
      state_d = S_START;
      timer_d = '0;
      bit_d   = '0;
      shift_d = head;
      par_d   = (PARITY == 1) ? ~^head : ^head;
    end

    // Line level and status follow the next state so they are registered in step with it
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_STOP) &&
             (bit_d == BIT_W'(STOP_BITS - 1)) &&
             (timer_d == TMR_W'(CLK_DIV - 1));
  end

  // Serialiser state register; reset abandons any frame in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign uart_tx    = tx_q;
  assign tx_busy    = busy_q;
  assign tx_done    = done_q;
  assign tx_ready   = ready_q;
  assign fifo_count = count_q;

endmodule

// File: doc/uart_transmitter.md
# uart_transmitter

Parametrised, buffered UART transmitter for the RISC-V SoC's serial console/debug path. Accepts characters over a valid/ready handshake into an internal FIFO and serialises them LSB-first. Frame format is configurable: data width, optional parity, one or two stop bits and baud divisor. Consecutive frames are sent back-to-back with no idle gap. It succeeds the fixed 8N1, unbuffered, send-enable transmitter.

## Interface
- `CLK_DIV`, 10416: clock cycles per bit (9600 baud at 100 MHz); legal range ≥ 2.
- `DATA_BITS`, 8: data bits per frame; legal 5–8.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: legal 1 or 2.
- `FIFO_DEPTH`, 4: entries; power of two, ≥ 2.

- `clk` input 1: single clock; all logic on rising edge.
- `rst` input 1: reset; one clock; reset is synchronous and active-high.
- `tx_valid` input 1: `tx_data` is valid this cycle.
- `tx_ready` output 1: FIFO can accept a write; push occurs on `tx_valid & tx_ready`.
- `tx_data` input DATA_BITS: character to send.
- `uart_tx` output 1: serial line, idle high; registered.
- `tx_busy` output 1: high while a frame is on the line (state ≠ IDLE).
- `tx_done` output 1: one-cycle pulse at the end of each frame's last stop bit.
- `fifo_count` output $clog2(FIFO_DEPTH)+1: entries currently stored.

## Operation
- **FIFO**
  - Circular buffer with wrapping read/write pointers and a registered count.
  - `tx_ready = (fifo_count < FIFO_DEPTH)`.
  - A write while `tx_ready` is low is ignored (no overwrite).
  - A simultaneous push and pop leaves the count unchanged.
  - A pop from an empty FIFO never occurs.
- **FSM states**
  - IDLE: `uart_tx` = 1. If count ≠ 0, pop, load the shift register and go to START.
  - START: `uart_tx` = 0.
  - DATA: shift register LSB, shifting right each bit, for DATA_BITS bits.
  - PARITY: present only if PARITY ≠ 0. Odd parity = `~^data`; even parity = `^data`.
  - STOP: `uart_tx` = 1 for STOP_BITS bits.
- **Bit timer**
  - Counts 0..CLK_DIV−1 and wraps; each state/bit lasts exactly CLK_DIV cycles.
  - Resets to 0 on every frame load.
  - A bit counter indexes DATA and STOP bits.
- **End of last stop bit**
  - `tx_done` pulses.
  - If FIFO is non-empty: pop and go directly to START, so the next start bit begins the following cycle.
  - Otherwise go to IDLE.
- **Reset**
  - Outputs: `uart_tx` = 1, `tx_busy` = 0, `tx_done` = 0, `fifo_count` = 0, `tx_ready` = 1.
  - Pointers, timer and FSM are cleared.
  - Asserting reset mid-frame abandons the frame, flushes the FIFO and drives the line high the next cycle.
- **Width rule**: the timer is $clog2(CLK_DIV) bits and never exceeds CLK_DIV−1.

## Timing
- Push at edge N: `fifo_count` = 1 after N.
  - The IDLE pop is at edge N+1.
  - `uart_tx` falls after edge N+1 (2-cycle latency from handshake to start bit).
- Frame length = (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × CLK_DIV cycles.
- `tx_busy` rises with the start bit and falls with `uart_tx` staying high after the final stop bit, when the FIFO is empty.
- `tx_done` is high for exactly the last cycle of the final stop bit, once per frame.
- `tx_ready` is registered-count based.
  - When the FIFO is full and a pop occurs at edge M, `tx_ready` is high after M.
  - A push in cycle M itself is not accepted.

## Test plan
- Single char, defaults with CLK_DIV=4, 0xA5.
  - Line pattern from start: 0,1,0,1,0,0,1,0,1,1, each 4 cycles.
  - Start bit 2 cycles after handshake.
  - One `tx_done` pulse at frame end.
- PARITY=2, STOP_BITS=2, DATA_BITS=7, CLK_DIV=3, 0x53.
  - Bits 0,1,1,0,0,1,0,1, parity 0, then 1,1.
  - 33-cycle frame.
  - PARITY=1 gives parity bit 1.
- Push 5 chars back-to-back with FIFO_DEPTH=4 while the first frame is sending.
  - All accepted via `tx_ready` stalls.
  - Frames are contiguous with zero idle cycles.
  - 5 `tx_done` pulses; `fifo_count` peaks at 4.
- Full FIFO plus `tx_valid` held with new data.
  - No overwrite; the dropped value never appears on the line.
  - Accepted after the next pop.
- Reset asserted mid-DATA with 3 queued chars.
  - Next cycle: `uart_tx` = 1, `fifo_count` = 0, `tx_busy` = 0.
  - No further frames are sent.
- Simultaneous push and pop at the frame boundary with count 1.
  - Count stays 1 and the next frame starts immediately.
